// File: rtl/spi_cmd_ctrl_if.sv
// Signal bundle between the SPI command controller, the SPI slave and the coefficient shadow bank.
// Signal names are seen from the controller: i_* are driven into it, o_* come out of it.
interface spi_cmd_ctrl_if #(
    parameter int unsigned P_DATA_NBITS = 24
);
    logic                      i_rx_cmd_rdy;
    logic                      i_rx_data_rdy;
    logic [P_DATA_NBITS+7:0]   i_rx_buf;
    logic                      i_frame_active;
    logic                      o_tx_load;
    logic [P_DATA_NBITS-1:0]   o_tx_data;
    logic                      o_coeff_we;
    logic                      o_coeff_re;
    logic [6:0]                o_coeff_addr;
    logic [P_DATA_NBITS-1:0]   o_coeff_wdata;
    logic [P_DATA_NBITS-1:0]   i_coeff_rdata;
    logic                      o_swap_req;
    logic                      i_swap_ack;
    logic                      o_busy;

    modport master (
        input  i_rx_cmd_rdy,
        input  i_rx_data_rdy,
        input  i_rx_buf,
        input  i_frame_active,
        input  i_coeff_rdata,
        input  i_swap_ack,
        output o_tx_load,
        output o_tx_data,
        output o_coeff_we,
        output o_coeff_re,
        output o_coeff_addr,
        output o_coeff_wdata,
        output o_swap_req,
        output o_busy
    );

    modport slave (
        output i_rx_cmd_rdy,
        output i_rx_data_rdy,
        output i_rx_buf,
        output i_frame_active,
        output i_coeff_rdata,
        output i_swap_ack,
        input  o_tx_load,
        input  o_tx_data,
        input  o_coeff_we,
        input  o_coeff_re,
        input  o_coeff_addr,
        input  o_coeff_wdata,
        input  o_swap_req,
        input  o_busy
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: coefficient read/write into the shadow bank, status register and
// bank-swap commit handshake. All outputs are registered copies of next-state decisions.
module spi_cmd_ctrl #(
    parameter int unsigned P_DATA_NBITS = 24,
    parameter int unsigned P_NCOEFF     = 40
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    spi_cmd_ctrl_if.master     bus
);

    localparam int unsigned CmdMsb     = P_DATA_NBITS + 7;
    localparam logic [6:0]  NCoeff     = 7'(P_NCOEFF);
    localparam logic [6:0]  AddrStatus = 7'h7E;
    localparam logic [6:0]  AddrCommit = 7'h7F;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StRdIssue,
        StRdLoad,
        StWaitData,
        StWr,
        StCommit,
        StAbort
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_rdy_q, data_rdy_q;
    logic [7:0]              cmd_q, cmd_d;
    logic                    err_range_q, err_range_d;
    logic                    err_abort_q, err_abort_d;
    logic                    err_overrun_q, err_overrun_d;
    logic [7:0]              wr_count_q, wr_count_d;
    logic                    tx_load_q, tx_load_d;
    logic [P_DATA_NBITS-1:0] tx_data_q, tx_data_d;
    logic                    coeff_we_q, coeff_we_d;
    logic                    coeff_re_q, coeff_re_d;
    logic [6:0]              coeff_addr_q, coeff_addr_d;
    logic [P_DATA_NBITS-1:0] coeff_wdata_q, coeff_wdata_d;
    logic                    swap_req_q, swap_req_d;
    logic                    busy_q, busy_d;

    logic                    cmd_edge, data_edge;
    logic                    cmd_is_read;
    logic [6:0]              cmd_addr;
    logic                    addr_in_range;
    logic [P_DATA_NBITS-1:0] status_word;

    assign cmd_edge      = bus.i_rx_cmd_rdy & ~cmd_rdy_q;
    assign data_edge     = bus.i_rx_data_rdy & ~data_rdy_q;
    assign cmd_is_read   = cmd_q[7];
    assign cmd_addr      = cmd_q[6:0];
    assign addr_in_range = (cmd_addr < NCoeff);

    always_comb begin
        status_word       = '0;
        status_word[15:0] = {err_range_q, err_abort_q, err_overrun_q, 5'b0, wr_count_q};
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        err_range_d   = err_range_q;
        err_abort_d   = err_abort_q;
        err_overrun_d = err_overrun_q;
        wr_count_d    = wr_count_q;
        tx_load_d     = 1'b0;
        tx_data_d     = tx_data_q;
        coeff_we_d    = 1'b0;
        coeff_re_d    = 1'b0;
        coeff_addr_d  = coeff_addr_q;
        coeff_wdata_d = coeff_wdata_q;
        swap_req_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_edge && bus.i_frame_active) begin
                    state_d = StDecode;
                    cmd_d   = bus.i_rx_buf[CmdMsb -: 8];
                end
            end
            StDecode: begin
                if (!bus.i_frame_active) begin
                    state_d = StAbort;
                end else if (cmd_is_read) begin
                    // Non-coefficient reads still pass through RD_ISSUE so load timing is fixed.
                    state_d = StRdIssue;
                    if (addr_in_range) begin
                        coeff_re_d   = 1'b1;
                        coeff_addr_d = cmd_addr;
                    end
                end else begin
                    state_d = StWaitData;
                end
            end
            StRdIssue: begin
                state_d = bus.i_frame_active ? StRdLoad : StAbort;
            end
            StRdLoad: begin
                if (!bus.i_frame_active) begin
                    state_d = StAbort;
                end else begin
                    state_d   = StWaitData;
                    tx_load_d = 1'b1;
                    if (addr_in_range) begin
                        tx_data_d = bus.i_coeff_rdata;
                    end else if (cmd_addr == AddrStatus) begin
                        tx_data_d = status_word;
                    end else begin
                        tx_data_d = '0;
                    end
                end
            end
            StWaitData: begin
                if (!bus.i_frame_active) begin
                    state_d = StAbort;
                end else if (data_edge) begin
                    if (cmd_is_read) begin
                        state_d = StIdle;
                    end else if (cmd_addr == AddrCommit) begin
                        state_d    = StCommit;
                        swap_req_d = 1'b1;
                    end else begin
                        state_d = StWr;
                        if (addr_in_range) begin
                            coeff_we_d    = 1'b1;
                            coeff_addr_d  = cmd_addr;
                            coeff_wdata_d = bus.i_rx_buf[P_DATA_NBITS-1:0];
                            if (wr_count_q != 8'hFF) begin
                                wr_count_d = wr_count_q + 8'd1;
                            end
                        end else if (cmd_addr == AddrStatus) begin
                            if (bus.i_rx_buf[0]) begin
                                err_range_d   = 1'b0;
                                err_abort_d   = 1'b0;
                                err_overrun_d = 1'b0;
                            end
                        end else begin
                            err_range_d = 1'b1;
                        end
                    end
                end
            end
            StWr: begin
                state_d = StIdle;
            end
            StCommit: begin
                // Frame end is ignored here; the swap must complete once requested.
                if (cmd_edge) begin
                    err_overrun_d = 1'b1;
                end
                if (bus.i_swap_ack) begin
                    state_d    = StIdle;
                    wr_count_d = '0;
                end else begin
                    swap_req_d = 1'b1;
                end
            end
            StAbort: begin
                err_abort_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= StIdle;
            cmd_rdy_q     <= 1'b0;
            data_rdy_q    <= 1'b0;
            cmd_q         <= '0;
            err_range_q   <= 1'b0;
            err_abort_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            wr_count_q    <= '0;
            tx_load_q     <= 1'b0;
            tx_data_q     <= '0;
            coeff_we_q    <= 1'b0;
            coeff_re_q    <= 1'b0;
            coeff_addr_q  <= '0;
            coeff_wdata_q <= '0;
            swap_req_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_rdy_q     <= bus.i_rx_cmd_rdy;
            data_rdy_q    <= bus.i_rx_data_rdy;
            cmd_q         <= cmd_d;
            err_range_q   <= err_range_d;
            err_abort_q   <= err_abort_d;
            err_overrun_q <= err_overrun_d;
            wr_count_q    <= wr_count_d;
            tx_load_q     <= tx_load_d;
            tx_data_q     <= tx_data_d;
            coeff_we_q    <= coeff_we_d;
            coeff_re_q    <= coeff_re_d;
            coeff_addr_q  <= coeff_addr_d;
            coeff_wdata_q <= coeff_wdata_d;
            swap_req_q    <= swap_req_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.o_tx_load     = tx_load_q;
    assign bus.o_tx_data     = tx_data_q;
    assign bus.o_coeff_we    = coeff_we_q;
    assign bus.o_coeff_re    = coeff_re_q;
    assign bus.o_coeff_addr  = coeff_addr_q;
    assign bus.o_coeff_wdata = coeff_wdata_q;
    assign bus.o_swap_req    = swap_req_q;
    assign bus.o_busy        = busy_q;

endmodule
